// File: rtl/ex_mul_sequencer_pkg.sv
// ============================================================================
// Module : ex_mul_sequencer_pkg
// Brief  : Shared types and constants for the EX-stage multiply sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_mul_sequencer_pkg;

   localparam int XLEN_DEFAULT = 32;

   // ALU control codes, shared with the ID/EX control decode
   localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
   localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
   localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
   localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
   localparam logic [3:0] ALU_CTRL_MUL = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

   function automatic logic is_mul_req(input logic [3:0] alu_ctrl);
      return (alu_ctrl == ALU_CTRL_MUL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mul_sequencer_mul_shift_add_dp.sv
// ============================================================================
// Module : mul_shift_add_dp
// Brief  : Shift-add multiply datapath: accumulator, multiplicand, multiplier.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_shift_add_dp
   import ex_mul_sequencer_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [XLEN-1:0] mcand_i,
   input  logic [XLEN-1:0] mplier_i,
   output logic [XLEN-1:0] acc_o,
   output logic            mplier_zero_o
);

   logic [XLEN-1:0] acc_q,    acc_d;
   logic [XLEN-1:0] mcand_q,  mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (load_i) begin
         acc_d    = '0;
         mcand_d  = mcand_i;
         mplier_d = mplier_i;
      end else if (step_i) begin
         // Adder wraps: only the low XLEN bits of the product are kept
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

   assign acc_o         = acc_q;
   assign mplier_zero_o = (mplier_q == '0);

endmodule

`default_nettype wire

// File: rtl/ex_mul_sequencer.sv
// ============================================================================
// Module : ex_mul_sequencer
// Brief  : EX-stage iterative multiply sequencer with pipeline stall control.
//          Optional MUL_EARLY_EXIT_EN ends the multiply once the multiplier
//          has shifted down to zero.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mul_sequencer
   import ex_mul_sequencer_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [3:0]      alu_ctrl_i,
   input  logic [XLEN-1:0] rs1_val_i,
   input  logic [XLEN-1:0] rs2_val_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int              CNT_W    = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   mul_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic w_mul_req;
   logic w_load;
   logic w_step;
   logic w_stall;
   logic w_early_exit;

   assign w_mul_req = is_mul_req(alu_ctrl_i);

`ifdef MUL_EARLY_EXIT_EN
   logic w_mplier_zero;
   assign w_early_exit = w_mplier_zero;
`else
   assign w_early_exit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_load  = 1'b0;
      w_step  = 1'b0;
      w_stall = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_mul_req) begin
               w_load  = 1'b1;
               w_stall = 1'b1;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            busy_o  = 1'b1;
            w_stall = 1'b1;
            if (w_early_exit) begin
               state_d = ST_DONE;
            end else begin
               w_step = 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_DONE;
               end
            end
         end
         // The MUL still in EX here is the one just finished, so no request
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Stall is combinational from the request, so mask it while in reset
   assign stall_o = w_stall & ~rst_i;

   mul_shift_add_dp #(
      .XLEN          (XLEN)
   ) u_dp (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .load_i        (w_load),
      .step_i        (w_step),
      .mcand_i       (rs1_val_i),
      .mplier_i      (rs2_val_i),
      .acc_o         (result_o),
`ifdef MUL_EARLY_EXIT_EN
      .mplier_zero_o (w_mplier_zero)
`else
      .mplier_zero_o ()
`endif
   );

endmodule

`default_nettype wire

// File: tb/tb_ex_mul_sequencer.sv
// ============================================================================
// Module : tb_ex_mul_sequencer
// Brief  : Self-checking bench for ex_mul_sequencer (MUL_EARLY_EXIT_EN aware).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mul_sequencer;

   logic        clk_i     = 1'b0;
   logic        rst_i     = 1'b0;
   logic [3:0]  alu_ctrl_i = 4'b0000;
   logic [31:0] rs1_val_i = '0;
   logic [31:0] rs2_val_i = '0;
   logic        stall_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   ex_mul_sequencer #(.XLEN(32)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .alu_ctrl_i (alu_ctrl_i),
      .rs1_val_i  (rs1_val_i),
      .rs2_val_i  (rs2_val_i),
      .stall_o    (stall_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Number of stalled BUSY cycles a MUL with this multiplier must take
   function automatic int busy_len(input logic [31:0] m);
      int msb;
`ifdef MUL_EARLY_EXIT_EN
      if (m == 0) return 1;
      msb = 0;
      for (int i = 0; i < 32; i++) if (m[i]) msb = i;
      return (msb + 2 < 32) ? msb + 2 : 32;
`else
      msb = 0;
      return 32 + msb;
`endif
   endfunction

   // Model: idle / busy-countdown / done-pulse, product by plain arithmetic
   int          m_busy = 0;
   bit          m_done = 1'b0;
   logic [31:0] m_prod = '0;
   logic [31:0] m_res  = '0;
   bit          m_rv   = 1'b1;

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_busy <= 0;
         m_done <= 1'b0;
         m_res  <= '0;
         m_rv   <= 1'b1;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_busy > 0) begin
         m_busy <= m_busy - 1;
         if (m_busy == 1) begin
            m_done <= 1'b1;
            m_res  <= m_prod;
            m_rv   <= 1'b1;
         end
      end else if (alu_ctrl_i == 4'b1111) begin
         m_busy <= busy_len(rs2_val_i);
         m_prod <= rs1_val_i * rs2_val_i;
         m_rv   <= 1'b0;
      end
   end

   always @(negedge clk_i) begin
      logic e_stall;
      e_stall = !rst_i && ((m_busy > 0) || (!m_done && alu_ctrl_i == 4'b1111));
      check("model stall_o", {31'd0, stall_o}, {31'd0, e_stall});
      check("model busy_o",  {31'd0, busy_o},  {31'd0, (m_busy > 0)});
      check("model done_o",  {31'd0, done_o},  {31'd0, m_done});
      if (m_rv) check("model result_o", result_o, m_res);
   end

   task automatic run_mul(input string nm, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_r, input int exp_c);
      int  cyc;
      bit  found;
      alu_ctrl_i = 4'b1111;
      rs1_val_i  = x;
      rs2_val_i  = y;
      #1;
      check({nm, " stall cycle0"}, {31'd0, stall_o}, 32'd1);
      check({nm, " busy cycle0"},  {31'd0, busy_o},  32'd0);
      cyc   = 0;
      found = 1'b0;
      while (!found && cyc < 100) begin
         @(posedge clk_i);
         #1;
         cyc++;
         if (done_o) found = 1'b1;
      end
      check({nm, " done cycle"}, cyc, exp_c);
      check({nm, " result"}, result_o, exp_r);
      check({nm, " stall in done"}, {31'd0, stall_o}, 32'd0);
   endtask

   task automatic idle_cycles(input int n);
      alu_ctrl_i = 4'b0000;
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      int done_seen;
`ifdef MUL_EARLY_EXIT_EN
      int c_76 = 5, c_ff5 = 5, c_big = 19, c_34 = 5, c_55 = 5, c_z = 2, c_53 = 4;
`else
      int c_76 = 33, c_ff5 = 33, c_big = 33, c_34 = 33, c_55 = 33, c_z = 33, c_53 = 33;
`endif
      #1 rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset stall_o",  {31'd0, stall_o}, 32'd0);
      check("reset busy_o",   {31'd0, busy_o},  32'd0);
      check("reset done_o",   {31'd0, done_o},  32'd0);
      check("reset result_o", result_o, 32'd0);
      rst_i = 1'b0;
      idle_cycles(2);

      run_mul("7x6", 32'd7, 32'd6, 32'd42, c_76);
      idle_cycles(3);
      run_mul("ffffffffx5", 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, c_ff5);
      idle_cycles(2);
      check("result holds after done", result_o, 32'hFFFF_FFFB);
      run_mul("10000x10000", 32'h0001_0000, 32'h0001_0000, 32'd0, c_big);
      idle_cycles(2);

      // Back-to-back: second MUL enters EX the cycle after the first DONE
      run_mul("3x4", 32'd3, 32'd4, 32'd12, c_34);
      @(posedge clk_i);
      #1;
      run_mul("5x5 back-to-back", 32'd5, 32'd5, 32'd25, c_55);
      idle_cycles(2);

      // Non-MUL ALU code never requests
      alu_ctrl_i = 4'b0010;
      rs1_val_i  = 32'd7;
      rs2_val_i  = 32'd6;
      done_seen  = 0;
      repeat (10) begin
         @(posedge clk_i);
         #1;
         if (done_o || stall_o || busy_o) done_seen++;
      end
      check("ADD held no activity", done_seen, 32'd0);

      // Asynchronous reset in the middle of BUSY
      alu_ctrl_i = 4'b1111;
      rs1_val_i  = 32'd123;
      rs2_val_i  = 32'hF000_0456;
      repeat (10) @(posedge clk_i);
      #3 rst_i = 1'b1;
      alu_ctrl_i = 4'b0000;
      #1;
      check("async rst stall_o",  {31'd0, stall_o}, 32'd0);
      check("async rst busy_o",   {31'd0, busy_o},  32'd0);
      check("async rst done_o",   {31'd0, done_o},  32'd0);
      check("async rst result_o", result_o, 32'd0);
      #2 rst_i = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(posedge clk_i);
         #1;
         if (done_o) done_seen++;
      end
      check("no done after reset", done_seen, 32'd0);

      run_mul("9x0", 32'd9, 32'd0, 32'd0, c_z);
      idle_cycles(2);
      run_mul("5x3", 32'd5, 32'd3, 32'd15, c_53);
      idle_cycles(2);
      run_mul("3x80000000", 32'd3, 32'h8000_0000, 32'h8000_0000, 33);
      idle_cycles(3);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

`default_nettype wire
